// File: rtl/imu_moving_average.sv
// imu_moving_average: per-axis boxcar moving average over the last 2^DEPTH_LOG2 sample sets.
// The six axes are processed serially through one shared add/subtract path.
//
// Ports:
//   CLOCK_50        system clock
//   RESET           asynchronous, active-high reset
//   DataValid       one-cycle strobe, the six raw axis inputs are valid
//   AccelX..GyroZ   raw unsigned samples, WIDTH bits each
//   AvgAccelX..Z,
//   AvgGyroX..Z     averaged outputs, held between AvgValid strobes
//   AvgValid        one-cycle strobe, all six averages updated together
//   Busy            a sample set is being processed; DataValid is dropped while high
//   Primed          window holds DEPTH real samples
//   Overrun         saturating count of dropped sample sets
//
// Configuration: define IMU_AVG_OVERRUN_EN to build the Overrun counter; otherwise Overrun is 0.
module imu_moving_average #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             DataValid,
  input  logic [WIDTH-1:0] AccelX,
  input  logic [WIDTH-1:0] AccelY,
  input  logic [WIDTH-1:0] AccelZ,
  input  logic [WIDTH-1:0] GyroX,
  input  logic [WIDTH-1:0] GyroY,
  input  logic [WIDTH-1:0] GyroZ,
  output logic [WIDTH-1:0] AvgAccelX,
  output logic [WIDTH-1:0] AvgAccelY,
  output logic [WIDTH-1:0] AvgAccelZ,
  output logic [WIDTH-1:0] AvgGyroX,
  output logic [WIDTH-1:0] AvgGyroY,
  output logic [WIDTH-1:0] AvgGyroZ,
  output logic             AvgValid,
  output logic             Busy,
  output logic             Primed,
  output logic [7:0]       Overrun
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned SW    = WIDTH + DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic {StIdle, StCalc} state_e;

  state_e                state_q, state_d;
  logic [2:0]            ch_q;
  logic [DEPTH_LOG2-1:0] wp_q;
  logic [CW-1:0]         count_q;
  logic [WIDTH-1:0]      hold_q   [6];
  logic [SW-1:0]         sum_q    [6];
  logic [WIDTH-1:0]      hist_q   [6][DEPTH];
  logic [WIDTH-1:0]      shadow_q [5];
  logic [WIDTH-1:0]      avg_q    [6];
  logic                  avg_valid_q;

  logic                  accept;
  logic                  last_ch;
  logic [WIDTH-1:0]      old_val;
  logic [SW-1:0]         new_sum;
  logic [WIDTH-1:0]      new_avg;

  // FSM next state
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last_ch = (ch_q == 3'd5);
    unique case (state_q)
      StIdle: begin
        if (DataValid) begin
          accept  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (last_ch) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shared add/subtract path. The history slot being replaced is part of the running sum, so
  // the subtraction never underflows.
  always_comb begin
    old_val = hist_q[ch_q][wp_q];
    new_sum = sum_q[ch_q] + SW'(hold_q[ch_q]) - SW'(old_val);
    new_avg = new_sum[SW-1:DEPTH_LOG2];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ch_q        <= '0;
      wp_q        <= '0;
      count_q     <= '0;
      avg_valid_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        hold_q[i] <= '0;
        sum_q[i]  <= '0;
        avg_q[i]  <= '0;
        for (int j = 0; j < int'(DEPTH); j++) hist_q[i][j] <= '0;
      end
      for (int i = 0; i < 5; i++) shadow_q[i] <= '0;
    end else begin
      avg_valid_q <= 1'b0;
      if (accept) begin
        hold_q[0] <= AccelX;
        hold_q[1] <= AccelY;
        hold_q[2] <= AccelZ;
        hold_q[3] <= GyroX;
        hold_q[4] <= GyroY;
        hold_q[5] <= GyroZ;
        ch_q      <= '0;
      end
      if (state_q == StCalc) begin
        sum_q[ch_q]        <= new_sum;
        hist_q[ch_q][wp_q] <= hold_q[ch_q];
        if (!last_ch) begin
          shadow_q[ch_q] <= new_avg;
          ch_q           <= ch_q + 3'd1;
        end else begin
          // All six outputs load on the same edge so downstream sees a coherent set.
          for (int i = 0; i < 5; i++) avg_q[i] <= shadow_q[i];
          avg_q[5]    <= new_avg;
          avg_valid_q <= 1'b1;
          wp_q        <= wp_q + 1'b1;
          ch_q        <= '0;
          if (count_q != CW'(DEPTH)) count_q <= count_q + 1'b1;
        end
      end
    end
  end

`ifdef IMU_AVG_OVERRUN_EN
  logic [7:0] overrun_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      overrun_q <= '0;
    end else if (DataValid && (state_q == StCalc) && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign Overrun = overrun_q;
`else
  assign Overrun = 8'd0;
`endif

  assign AvgAccelX = avg_q[0];
  assign AvgAccelY = avg_q[1];
  assign AvgAccelZ = avg_q[2];
  assign AvgGyroX  = avg_q[3];
  assign AvgGyroY  = avg_q[4];
  assign AvgGyroZ  = avg_q[5];
  assign AvgValid  = avg_valid_q;
  assign Busy      = (state_q == StCalc);
  assign Primed    = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_imu_moving_average.sv
// Directed bench for imu_moving_average: reset, ramp, wrap/step, per-axis independence,
// overrun and reset during processing. Expected values are hand-derived from the window rules.
module tb_imu_moving_average;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic [9:0] ax, ay, az, gx, gy, gz;
  logic [9:0] oax, oay, oaz, ogx, ogy, ogz;
  logic       avg_valid, busy, primed;
  logic [7:0] overrun;

  int n_checks = 0;
  int n_errors = 0;
  int av_count = 0;

  logic [5:0][9:0] avg_all;
  assign avg_all = {ogz, ogy, ogx, oaz, oay, oax};

  always #5 clk = ~clk;

  imu_moving_average #(.WIDTH(10), .DEPTH_LOG2(3)) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .DataValid (data_valid),
    .AccelX    (ax),
    .AccelY    (ay),
    .AccelZ    (az),
    .GyroX     (gx),
    .GyroY     (gy),
    .GyroZ     (gz),
    .AvgAccelX (oax),
    .AvgAccelY (oay),
    .AvgAccelZ (oaz),
    .AvgGyroX  (ogx),
    .AvgGyroY  (ogy),
    .AvgGyroZ  (ogz),
    .AvgValid  (avg_valid),
    .Busy      (busy),
    .Primed    (primed),
    .Overrun   (overrun)
  );

  always @(posedge clk) if (avg_valid === 1'b1) av_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input logic [5:0][9:0] v);
    ax = v[0]; ay = v[1]; az = v[2]; gx = v[3]; gy = v[4]; gz = v[5];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_avg", avg_all[0] | avg_all[1] | avg_all[2] | avg_all[3] | avg_all[4]
             | avg_all[5], 0);
    check_eq("rst_flags", {avg_valid, busy, primed}, 0);
    check_eq("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one set, check Busy after capture edge T, no AvgValid before T+6, AvgValid after T+6.
  task automatic run_set(input logic [5:0][9:0] v);
    logic early;
    early = 1'b0;
    @(posedge clk); #1;
    set_inputs(v);
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    check_eq("busy_after_capture", busy, 1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (avg_valid) early = 1'b1;
    end
    check_eq("no_early_avg_valid", early, 0);
    @(posedge clk); #1;
    check_eq("avg_valid_t6", avg_valid, 1);
    @(posedge clk); #1;
    check_eq("avg_valid_one_cycle", {avg_valid, busy}, 0);
  endtask

  initial begin
    logic [5:0][9:0] v;
    int base;
    rst = 1'b1;
    data_valid = 1'b0;
    set_inputs('0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Ramp: all axes 512, averages 64*k
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < 6; i++) v[i] = 10'd512;
      run_set(v);
      check_eq("ramp_ax", oax, 64 * k);
      check_eq("ramp_gz", ogz, 64 * k);
      check_eq("ramp_primed", primed, (k == 8) ? 1 : 0);
      repeat (12) @(posedge clk);
      #1;
    end

    // Mid-run reset clears history and Primed
    do_reset();

    // Wrap/step: 8 sets of 1023 then 8 of 0
    for (int k = 1; k <= 16; k++) begin
      for (int i = 0; i < 6; i++) v[i] = (k <= 8) ? 10'd1023 : 10'd0;
      run_set(v);
      // window sum = 1023 * (number of 1023 entries in the window)
      check_eq("step_ay", oay, (1023 * ((k <= 8) ? k : 16 - k)) >> 3);
      check_eq("step_gx", ogx, (1023 * ((k <= 8) ? k : 16 - k)) >> 3);
    end
    check_eq("step_primed_held", primed, 1);

    // Per-axis independence
    do_reset();
    for (int i = 0; i < 6; i++) v[i] = 10'(8 * (i + 1));
    run_set(v);
    for (int i = 0; i < 6; i++) check_eq("axis_first", avg_all[i], i + 1);
    for (int k = 2; k <= 8; k++) run_set(v);
    for (int i = 0; i < 6; i++) check_eq("axis_settled", avg_all[i], 8 * (i + 1));

    // Overrun: second strobe at T+3 dropped
    do_reset();
    base = av_count;
    for (int i = 0; i < 6; i++) v[i] = 10'd80;
    @(posedge clk); #1;
    set_inputs(v);
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("overrun_one_avg_valid", av_count - base, 1);
    check_eq("overrun_avg", oax, 10);
`ifdef IMU_AVG_OVERRUN_EN
    check_eq("overrun_one", overrun, 1);
`else
    check_eq("overrun_one", overrun, 0);
`endif
    // Continuous strobe: about six drops per accepted set, well over 255 total
    data_valid = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifdef IMU_AVG_OVERRUN_EN
    check_eq("overrun_sat", overrun, 255);
`else
    check_eq("overrun_sat", overrun, 0);
`endif

    // Reset during CALC aborts without AvgValid
    do_reset();
    base = av_count;
    for (int i = 0; i < 6; i++) v[i] = 10'd400;
    @(posedge clk); #1;
    set_inputs(v);
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort_no_avg_valid", av_count - base, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_avg", oax, 0);
    for (int i = 0; i < 6; i++) v[i] = 10'd800;
    run_set(v);
    for (int i = 0; i < 6; i++) check_eq("abort_fresh_avg", avg_all[i], 100);
    check_eq("abort_primed", primed, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
